// File: rtl/frame_pattern_gen_if.sv
// Pixel write-port bundle between the pattern generator and the SDRAM write arbiter.
interface frame_pattern_gen_if;
    logic        wr_en;
    logic        data_en;
    logic [15:0] dout;

    modport master (input wr_en, output data_en, output dout);
    modport slave  (output wr_en, input data_en, input dout);
endinterface

// File: rtl/frame_pattern_gen.sv
// Synthetic RGB565 frame source: streams one raster-order frame per start pulse,
// throttled by the arbiter's wr_en level, with four selectable test patterns.
module frame_pattern_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [1:0]                 pat_sel,
    frame_pattern_gen_if.master        pix,
    output logic                       busy_o,
    output logic                       frame_done_o,
    output logic [7:0]                 frame_cnt_o
);
    localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [7:0]  BAR_LAST = 8'(H_ACTIVE / 8 - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [10:0] x;
    logic [9:0]  y;
    logic [1:0]  pat_q;
    logic [7:0]  bar_cnt;
    logic [2:0]  bar_idx;
    logic        emit, last_pix, launch;
    logic [15:0] pix_val;
    logic [15:0] bar_rgb;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A start pulse coinciding with the final pixel is dropped: launch only fires from IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i)  state_nxt = RUN;
            RUN:     if (last_pix) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        launch   = (state == IDLE) && start_i;
        emit     = (state == RUN) && pix.wr_en;
        last_pix = emit && (x == X_LAST) && (y == Y_LAST);
    end

    always_comb begin
        case (bar_idx)
            3'd0:    bar_rgb = 16'hFFFF;
            3'd1:    bar_rgb = 16'hFFE0;
            3'd2:    bar_rgb = 16'h07FF;
            3'd3:    bar_rgb = 16'h07E0;
            3'd4:    bar_rgb = 16'hF81F;
            3'd5:    bar_rgb = 16'hF800;
            3'd6:    bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase
    end

    // frame_cnt_o only moves after the last pixel, so it is the frame-start count here.
    always_comb begin
        case (pat_q)
            2'd0:    pix_val = bar_rgb;
            2'd1:    pix_val = {x[9:5], y[9:4], frame_cnt_o[4:0]};
            2'd2:    pix_val = (x[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
            default: pix_val = (x[9:4] == frame_cnt_o[5:0]) ? 16'hFFFF : 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix.data_en  <= 1'b0;
            pix.dout     <= 16'h0000;
            frame_done_o <= 1'b0;
            frame_cnt_o  <= 8'd0;
            x            <= 11'd0;
            y            <= 10'd0;
            pat_q        <= 2'd0;
            bar_cnt      <= 8'd0;
            bar_idx      <= 3'd0;
        end else begin
            pix.data_en  <= emit;
            frame_done_o <= last_pix;
            if (last_pix) frame_cnt_o <= frame_cnt_o + 8'd1;
            if (launch) begin
                pat_q   <= pat_sel;
                x       <= 11'd0;
                y       <= 10'd0;
                bar_cnt <= BAR_LAST;
                bar_idx <= 3'd0;
            end
            if (emit) begin
                pix.dout <= pix_val;
                if (x == X_LAST) begin
                    x       <= 11'd0;
                    y       <= (y == Y_LAST) ? 10'd0 : y + 10'd1;
                    bar_cnt <= BAR_LAST;
                    bar_idx <= 3'd0;
                end else begin
                    x <= x + 11'd1;
                    if (bar_cnt == 8'd0) begin
                        bar_cnt <= BAR_LAST;
                        bar_idx <= bar_idx + 3'd1;
                    end else begin
                        bar_cnt <= bar_cnt - 8'd1;
                    end
                end
            end
        end
    end

    assign busy_o = (state == RUN);
endmodule

// File: tb/tb_frame_pattern_gen.sv
// Scoreboard bench for frame_pattern_gen on a reduced 64x4 raster.
module tb_frame_pattern_gen;
    localparam int H = 64;
    localparam int V = 4;
    localparam int N = H * V;

    typedef struct {
        logic [15:0] pix;
        bit          last;
        logic [7:0]  fc_after;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic [1:0] pat_sel = 2'd0;
    logic       busy_o, frame_done_o;
    logic [7:0] frame_cnt_o;

    frame_pattern_gen_if bus();

    frame_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .pat_sel(pat_sel),
        .pix(bus), .busy_o(busy_o), .frame_done_o(frame_done_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          model_fc = 0;
    int          done_cnt = 0;
    bit          wr_prev = 1'b0;
    logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_pix(input int p, input int x, input int y, input int fc);
        int r, g, b;
        case (p)
            0: return bars[x / (H / 8)];
            1: begin
                r = (x >> 5) & 31; g = (y >> 4) & 63; b = fc & 31;
                return 16'((r << 11) | (g << 5) | b);
            end
            2: return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 16'hFFFF : 16'h0000;
            default: return (((x >> 4) & 63) == (fc & 63)) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Pulse start from IDLE and queue the whole frame the model expects.
    task automatic start_frame(input int p);
        exp_t e;
        pat_sel = 2'(p);
        start_i = 1'b1;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                e.pix      = model_pix(p, x, y, model_fc);
                e.last     = (x == H - 1) && (y == V - 1);
                e.fc_after = 8'((model_fc + 1) & 255);
                sb.push_back(e);
            end
        model_fc = (model_fc + 1) & 255;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((sb.size() != 0 || busy_o) && n < bound) begin
            tick();
            n++;
        end
        check("frame_drain_timeout", int'(n >= bound), 0);
    endtask

    // Monitor: pops one expected pixel per data_en and cross-checks frame_done/frame_cnt.
    always @(negedge clk) begin
        bit   exp_done;
        exp_t e;
        exp_done = 1'b0;
        if (!rst) begin
            if (bus.data_en) begin
                check("data_en_after_stall", int'(wr_prev), 1);
                if (sb.size() == 0) begin
                    check("unexpected_pixel", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("pixel", int'(bus.dout), int'(e.pix));
                    if (e.last) begin
                        exp_done = 1'b1;
                        check("frame_cnt_at_done", int'(frame_cnt_o), int'(e.fc_after));
                    end
                end
            end
            check("frame_done", int'(frame_done_o), int'(exp_done));
            if (frame_done_o) done_cnt++;
        end
        wr_prev = bus.wr_en;
    end

    initial begin
        bus.wr_en = 1'b0;
        // Reset held with start asserted.
        rst = 1'b1; start_i = 1'b1;
        repeat (3) tick();
        check("rst_data_en", int'(bus.data_en), 0);
        check("rst_dout", int'(bus.dout), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(frame_done_o), 0);
        check("rst_frame_cnt", int'(frame_cnt_o), 0);
        rst = 1'b0; start_i = 1'b0;
        tick();

        // Colour bars, wr_en held high: latency and busy.
        bus.wr_en = 1'b1;
        start_frame(0);
        check("busy_after_start", int'(busy_o), 1);
        check("first_pix_early", int'(bus.data_en), 0);
        tick();
        check("first_pix_latency", int'(bus.data_en), 1);
        check("first_pix_white", int'(bus.dout), 16'hFFFF);
        wait_idle(N + 20);
        check("bars_frame_cnt", int'(frame_cnt_o), 1);
        check("bars_done_cnt", done_cnt, 1);

        // Gradient under random backpressure.
        start_frame(1);
        for (int i = 0; i < 4 * N && sb.size() != 0; i++) begin
            bus.wr_en = 1'($urandom_range(0, 1));
            tick();
        end
        bus.wr_en = 1'b1;
        wait_idle(20);
        check("bp_frame_cnt", int'(frame_cnt_o), 2);

        // Overlapping starts: mid-frame and on the final-pixel cycle are both ignored.
        start_frame(2);
        for (int i = 1; i < N; i++) begin
            start_i = (i == 50);
            tick();
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("busy_falls", int'(busy_o), 0);
        repeat (10) tick();
        check("overlap_busy_idle", int'(busy_o), 0);
        check("overlap_done_cnt", done_cnt, 3);
        check("overlap_frame_cnt", int'(frame_cnt_o), 3);
        start_frame(2);
        wait_idle(N + 20);
        check("frame2_cnt", int'(frame_cnt_o), 4);

        // Reset mid-frame aborts without a done pulse.
        start_frame(0);
        repeat (100) tick();
        rst = 1'b1;
        tick();
        check("midrst_data_en", int'(bus.data_en), 0);
        check("midrst_dout", int'(bus.dout), 0);
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_done", int'(frame_done_o), 0);
        check("midrst_frame_cnt", int'(frame_cnt_o), 0);
        sb.delete();
        model_fc = 0;
        rst = 1'b0;
        tick();

        // Moving bar over three frames; pat_sel change mid-frame must not take effect.
        for (int f = 0; f < 3; f++) begin
            start_frame(3);
            repeat (30) tick();
            pat_sel = 2'd0;
            wait_idle(N + 20);
        end
        check("movbar_frame_cnt", int'(frame_cnt_o), 3);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_pattern_gen.md
# frame_pattern_gen

Synthetic frame source for the SDRAM write path of the SDRAM-VGA experiment. On each frame-sync pulse it streams exactly H_ACTIVE×V_ACTIVE RGB565 pixels in raster order into the memory write port, throttled by the arbiter's write-ready level. Output is one of four selectable test patterns, so the SDRAM and VGA read chain can be checked visually and by bench.

## Interface
- H_ACTIVE, 1024, pixels per line; must be a multiple of 8 and ≤ 2047.
- V_ACTIVE, 768, lines per frame; must be ≤ 1023.
- clk  in  1  write-side clock (50 MHz domain).
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  frame-sync pulse, one cycle, launches a frame.
- wr_en  in  1  arbiter ready-to-write level; gen may emit a pixel in any cycle it is high.
- pat_sel  in  2  pattern select, sampled at frame start.
- data_en  out  1  pixel valid strobe.
- dout  out  16  pixel, RGB565 ({r[4:0], g[5:0], b[4:0]}).
- busy_o  out  1  high while a frame is in progress.
- frame_done_o  out  1  one-cycle pulse after the last pixel of a frame.
- frame_cnt_o  out  8  completed-frame count, wraps 255→0.

## Operation
- States:
  - IDLE: waiting for start_i.
  - RUN: streaming pixels.
- IDLE→RUN on start_i=1. In that cycle:
  - pat_sel is latched into pat_q.
  - x (11 b) and y (10 b) are cleared.
  - bar counter and bar index are cleared.
- In RUN, each cycle with wr_en=1 emits the pixel at (x,y) and advances:
  - x increments.
  - At x=H_ACTIVE-1, x goes to 0 and y increments.
- RUN→IDLE in the cycle the pixel (H_ACTIVE-1, V_ACTIVE-1) is emitted. That cycle also issues frame_done_o next cycle and increments frame_cnt.
- wr_en=0 in RUN: no emission and counters hold. No timeout.
- start_i while in RUN is ignored. The frame is never restarted.
- start_i in the same cycle as the final-pixel transition is also ignored, so the next frame needs a later pulse.
- Patterns (pat_q):
  - 0, colour bars: 8 vertical bars, each H_ACTIVE/8 wide, left to right. Values are FFFF white, FFE0 yellow, 07FF cyan, 07E0 green, F81F magenta, F800 red, 001F blue, 0000 black. The bar index comes from a down-counter reloaded with H_ACTIVE/8-1 each bar and each line; no divider.
  - 1, gradient: r=x[9:5], g=y[9:4], b=frame_cnt[4:0].
  - 2, checkerboard: dout = (x[5]^y[5]) ? FFFF : 0000.
  - 3, moving bar: dout = (x[9:4]==frame_cnt[5:0]) ? FFFF : 0000. The 16-px white column shifts right one position per frame.
- All arithmetic is unsigned. Counters never exceed their terminal values. frame_cnt wraps modulo 256.

## Timing
- Reset values: data_en=0, dout=0000, busy_o=0, frame_done_o=0, frame_cnt_o=0, state=IDLE, x=y=0, pat_q=0.
- Reset asserted mid-frame aborts at the next edge to the reset values. No partial-frame pulse is issued.
- All outputs are registered.
- data_en(t+1) = RUN(t) & wr_en(t). dout(t+1) is the pixel at (x(t),y(t)).
- Latency from start_i to the first data_en is 2 cycles when wr_en is held high.
- wr_en must be a FIFO not-almost-full level with ≥1 entry of margin, because of the 1-cycle output lag.
- busy_o is high from the cycle after start_i until the cycle after the final pixel is emitted.
- frame_done_o and the frame_cnt_o increment coincide with data_en for the final pixel.
- Pattern 3 and the gradient blue channel use frame_cnt as it was at frame start, since frame_cnt only changes after the final pixel.
- Throughput is 1 pixel/cycle; a frame takes H_ACTIVE×V_ACTIVE cycles plus stall cycles.

## Test plan
- Reset check: hold rst 3 cycles with start_i=1 → all outputs at their reset values, busy_o=0.
- Colour bars, H=1024, V=768, wr_en=1, pat_sel=0, start pulse:
  - first data_en 2 cycles later, dout=FFFF.
  - pixel 128 = FFE0; pixel 1023 = 0000; pixel 1024 (line 1, x=0) = FFFF.
  - exactly 786432 data_en cycles in total.
  - frame_done_o on the last one, frame_cnt_o=1.
- Backpressure, small params H=16, V=2: toggle wr_en in a pseudo-random pattern → 32 pixels in exact raster order, no duplicates or gaps, data_en never high in a cycle after wr_en=0.
- Overlap: start_i mid-frame, then on the final-pixel cycle → both ignored, single frame_done_o, busy_o falls. A later start_i begins frame 2.
- Pattern 3 over 3 frames with H=64, V=1 → white pixels are x 0–15, then 16–31, then 32–47. A pat_sel change mid-frame has no effect until the next start.
- Reset mid-frame: assert rst after 500 pixels → outputs reset next edge, frame_cnt_o=0. A new start_i restarts at (0,0).
